// File: rtl/seq_scan_ctrl.sv
// Windowed scan controller: runs an overlapping Mealy pattern matcher over a
// serial bit stream and stops on window expiry, match limit or abort.
module seq_scan_ctrl #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1001,
    parameter int                 CNT_W   = 8,
    parameter int                 WIN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] match_limit,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       reason
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] R_NONE  = 2'b00;
    localparam logic [1:0] R_WIN   = 2'b01;
    localparam logic [1:0] R_LIMIT = 2'b10;
    localparam logic [1:0] R_ABORT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIN_W:0]   PAT_LEN = (WIN_W + 1)'(PAT_W);

    logic [1:0]       state_q,  state_d;
    logic [WIN_W-1:0] win_q,    win_d;
    logic [CNT_W-1:0] lim_q,    lim_d;
    logic [PAT_W-2:0] hist_q,   hist_d;
    logic [WIN_W-1:0] seen_q,   seen_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       reason_q, reason_d;
    logic             hit_q,    hit_d;

    logic             accept;
    logic [PAT_W-1:0] nh;
    logic [WIN_W:0]   seen_nx;
    logic             match;
    logic [CNT_W-1:0] cnt_inc;
    logic             lim_hit;
    logic             win_hit;

    assign in_ready  = (state_q == S_RUN) && !abort;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign hit       = hit_q;
    assign hit_count = cnt_q;
    assign reason    = reason_q;

    assign accept  = in_valid && in_ready;
    assign nh      = {hist_q, in_bit};
    assign seen_nx = {1'b0, seen_q} + 1'b1;

    // Matches are suppressed until a full pattern's worth of bits has
    // arrived, so the all-zero reset history cannot fake a hit.
    assign match   = accept && (nh == PATTERN) && (seen_nx >= PAT_LEN);
    assign cnt_inc = (match && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
    assign lim_hit = match && (lim_q != '0) && (cnt_inc == lim_q);
    assign win_hit = (seen_nx == {1'b0, win_q});

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        lim_d    = lim_q;
        hist_d   = hist_q;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        reason_d = reason_q;
        hit_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    win_d    = win_len;
                    lim_d    = match_limit;
                    hist_d   = '0;
                    seen_d   = '0;
                    cnt_d    = '0;
                    reason_d = R_NONE;
                    if (win_len == '0) begin
                        state_d  = S_DONE;
                        reason_d = R_WIN;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d  = S_DONE;
                    reason_d = R_ABORT;
                end else if (accept) begin
                    hist_d = nh[PAT_W-2:0];
                    seen_d = seen_nx[WIN_W-1:0];
                    cnt_d  = cnt_inc;
                    hit_d  = match;
                    if (lim_hit) begin
                        state_d  = S_DONE;
                        reason_d = R_LIMIT;
                    end else if (win_hit) begin
                        state_d  = S_DONE;
                        reason_d = R_WIN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            lim_q    <= '0;
            hist_q   <= '0;
            seen_q   <= '0;
            cnt_q    <= '0;
            reason_q <= R_NONE;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            lim_q    <= lim_d;
            hist_q   <= hist_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            reason_q <= reason_d;
            hit_q    <= hit_d;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus a random
// stream checked against a queue-based model of the overlapping matcher.
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] win_len;
    logic [7:0]  match_limit;
    logic        in_valid;
    logic        in_bit;

    logic        in_ready, hit, busy, done;
    logic [7:0]  hit_count;
    logic [1:0]  reason;

    logic        z_in_ready, z_hit, z_busy, z_done;
    logic [7:0]  z_hit_count;
    logic [1:0]  z_reason;

    int nvec = 0;
    int nerr = 0;

    logic [3:0] pat = 4'b1001;

    seq_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .win_len(win_len), .match_limit(match_limit),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .hit(hit), .hit_count(hit_count), .busy(busy), .done(done),
        .reason(reason)
    );

    seq_scan_ctrl #(.PATTERN(4'b0000)) dut_z (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .win_len(win_len), .match_limit(match_limit),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(z_in_ready),
        .hit(z_hit), .hit_count(z_hit_count), .busy(z_busy), .done(z_done),
        .reason(z_reason)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int w, input int l);
        start       = 1'b1;
        win_len     = 16'(w);
        match_limit = 8'(l);
        in_valid    = 1'b0;
        abort       = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1; start = 0; abort = 0; in_valid = 0; in_bit = 0;
        win_len = 0; match_limit = 0;
        #3;
        got = {in_ready, hit, busy, done, reason, hit_count};
        nvec++;
        if (got !== 14'd0) begin
            nerr++;
            $display("FAIL reset: outputs=%h want 0", got);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_window();
        logic [6:0]  s = 7'b1001001;
        logic [7:0]  c = 0;
        logic        eh, ed;
        logic [12:0] got, exp;
        start_run(7, 0);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_bit   = s[6-i];
            #1;
            nvec++;
            if (in_ready !== 1'b1) begin
                nerr++;
                $display("FAIL win_ready bit%0d: in_ready=%b want 1", i, in_ready);
            end
            tick();
            eh = (i == 3) || (i == 6);
            ed = (i == 6);
            if (eh) c++;
            got = {hit, hit_count, done, busy, reason};
            exp = {eh, c, ed, ~ed, ed ? 2'b01 : 2'b00};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL win_bit%0d: {hit,cnt,done,busy,rsn}=%h want %h",
                         i, got, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        got = {hit, hit_count, done, busy, reason};
        exp = {1'b0, 8'd2, 1'b0, 1'b0, 2'b01};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL win_hold: got %h want %h", got, exp);
        end
    endtask

    task automatic test_limit();
        logic [7:0]  s = 8'b10011001;
        logic [12:0] got, exp;
        start_run(16, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bit   = s[7-i];
            tick();
            got = {hit, hit_count, done, busy, reason};
            exp = (i == 3) ? {1'b1, 8'd1, 1'b1, 1'b0, 2'b10}
                           : {1'b0, 8'd0, 1'b0, 1'b1, 2'b00};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL limit_bit%0d: got %h want %h", i, got, exp);
            end
        end
        in_bit = s[3];
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL limit_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        nvec++;
        if ({in_ready, hit_count, reason} !== {1'b0, 8'd1, 2'b10}) begin
            nerr++;
            $display("FAIL limit_idle: rdy=%b cnt=%0d rsn=%b want 0/1/10",
                     in_ready, hit_count, reason);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_win();
        start       = 1'b1;
        win_len     = 16'd0;
        match_limit = 8'd0;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL zwin_idle_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        start = 1'b0;
        nvec++;
        if ({done, busy, in_ready, reason, hit_count}
            !== {1'b1, 1'b0, 1'b0, 2'b01, 8'd0}) begin
            nerr++;
            $display("FAIL zwin_done: done=%b busy=%b rdy=%b rsn=%b cnt=%0d",
                     done, busy, in_ready, reason, hit_count);
        end
        tick();
        nvec++;
        if ({done, in_ready} !== 2'b00) begin
            nerr++;
            $display("FAIL zwin_after: done=%b rdy=%b want 0 0", done, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_abort();
        logic [1:0] b2 = 2'b10;
        start_run(16, 0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_bit   = b2[1-i];
            tick();
        end
        abort  = 1'b1;
        in_bit = 1'b0;
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL abort_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        nvec++;
        if ({done, busy, reason, hit_count} !== {1'b1, 1'b0, 2'b11, 8'd0}) begin
            nerr++;
            $display("FAIL abort_done: done=%b busy=%b rsn=%b cnt=%0d",
                     done, busy, reason, hit_count);
        end
        tick();
        start_run(16, 0);
        nvec++;
        if ({busy, reason, hit_count} !== {1'b1, 2'b00, 8'd0}) begin
            nerr++;
            $display("FAIL abort_restart: busy=%b rsn=%b cnt=%0d",
                     busy, reason, hit_count);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_bit   = (i == 1);
            tick();
            nvec++;
            if (hit !== 1'b0) begin
                nerr++;
                $display("FAIL abort_clear bit%0d: hit=%b want 0", i, hit);
            end
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int hits = 0;
        int at   = -1;
        int cyc  = 0;
        start_run(16, 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bit   = pat[3-i];
            tick();
            cyc++;
            if (hit) begin hits++; at = cyc; end
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                in_bit = 1'($urandom_range(0, 1));
                tick();
                cyc++;
                if (hit) begin hits++; at = cyc; end
            end
        end
        nvec++;
        if (hits != 1 || at != 13 || hit_count !== 8'd1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL backpressure: hits=%0d at=%0d cnt=%0d busy=%b want 1/13/1/1",
                     hits, at, hit_count, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        int m = 0;
        start_run(1000, 0);
        for (int i = 0; i < 800; i++) begin
            in_valid = 1'b1;
            in_bit   = (i % 3 == 0);
            if (i >= 3 && i % 3 == 0 && m < 255) m++;
            tick();
        end
        in_valid = 1'b0;
        nvec++;
        if (hit_count !== 8'(m) || busy !== 1'b1) begin
            nerr++;
            $display("FAIL saturate: cnt=%0d busy=%b want %0d/1", hit_count, busy, m);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit          q[$];
        logic [7:0]  mc;
        logic        ab, v, b, eh, ed, fin;
        logic [1:0]  er;
        logic [12:0] got, exp;
        int          w, l, n, cyc;
        for (int r = 0; r < 25; r++) begin
            w = $urandom_range(1, 40);
            l = $urandom_range(0, 3);
            q.delete();
            mc  = 0;
            fin = 0;
            cyc = 0;
            start_run(w, l);
            while (!fin && cyc < 500) begin
                ab = ($urandom_range(0, 29) == 0);
                v  = ($urandom_range(0, 9) < 7);
                b  = 1'($urandom_range(0, 1));
                abort = ab; in_valid = v; in_bit = b;
                #1;
                nvec++;
                if (in_ready !== !ab) begin
                    nerr++;
                    $display("FAIL rnd_ready r%0d c%0d: in_ready=%b want %b",
                             r, cyc, in_ready, !ab);
                end
                tick();
                eh = 0; ed = 0; er = 2'b00;
                if (ab) begin
                    ed = 1; er = 2'b11;
                end else if (v) begin
                    q.push_back(b);
                    n = q.size();
                    if (n >= 4 && {q[n-4], q[n-3], q[n-2], q[n-1]} == pat) begin
                        eh = 1;
                        if (mc != 8'd255) mc++;
                    end
                    if (l != 0 && eh && int'(mc) == l) begin
                        ed = 1; er = 2'b10;
                    end else if (n == w) begin
                        ed = 1; er = 2'b01;
                    end
                end
                got = {hit, hit_count, done, busy, reason};
                exp = {eh, mc, ed, ~ed, er};
                nvec++;
                if (got !== exp) begin
                    nerr++;
                    $display("FAIL rnd r%0d c%0d: {hit,cnt,done,busy,rsn}=%h want %h",
                             r, cyc, got, exp);
                end
                fin = ed;
                cyc++;
            end
            abort = 0; in_valid = 0;
            if (!fin) begin
                nvec++;
                nerr++;
                $display("FAIL rnd_timeout r%0d: run never ended, got done=%b want 1",
                         r, done);
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_rst_midrun();
        logic [4:0]  s = 5'b10011;
        logic [13:0] got;
        start_run(16, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = s[4-i];
            tick();
        end
        nvec++;
        if (hit_count !== 8'd1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL rst_pre: cnt=%0d busy=%b want 1/1", hit_count, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        got = {in_ready, hit, busy, done, reason, hit_count};
        nvec++;
        if (got !== 14'd0 || z_busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_async: outputs=%h z_busy=%b want 0", got, z_busy);
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        start_run(16, 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b0;
            tick();
            nvec++;
            if (z_hit !== (i == 3) || z_hit_count !== 8'((i == 3) ? 1 : 0)) begin
                nerr++;
                $display("FAIL zero_pat bit%0d: hit=%b cnt=%0d want %b",
                         i, z_hit, z_hit_count, (i == 3));
            end
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_window();
        test_limit();
        test_zero_win();
        test_abort();
        test_backpressure();
        test_saturate();
        test_random();
        test_rst_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
